// File: rtl/alu_operand_sequencer_if.sv
// ALU-side bus of the operand sequencer: registered operands/opcode out,
// combinational Result/Status back. Sequencer is master, ALU is slave.
interface alu_operand_sequencer_if #(parameter int C_WIDTH = 8);
  logic [C_WIDTH-1:0] A;
  logic [C_WIDTH-1:0] B;
  logic [1:0]         OpCode;
  logic [C_WIDTH-1:0] AluResult;
  logic [3:0]         AluStatus;

  modport master (output A, B, OpCode, input AluResult, AluStatus);
  modport slave  (input A, B, OpCode, output AluResult, AluStatus);
endinterface

// File: rtl/alu_operand_sequencer.sv
// Collects A, B and opcode over Enter presses, runs one ALU cycle, shows result.
// Optional macro ALU_SEQ_CHAIN_EN: Enter in SHOW chains ResultReg into A.
module alu_operand_sequencer #(
  parameter int C_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [C_WIDTH-1:0]     DataIn,
  input  logic                   Enter,
  input  logic                   Undo,
  alu_operand_sequencer_if.master alu,
  output logic [C_WIDTH-1:0]     ResultReg,
  output logic [3:0]             StatusReg,
  output logic                   Valid,
  output logic [2:0]             Stage
);

  typedef enum logic [2:0] {
    WAIT_A  = 3'd0,
    WAIT_B  = 3'd1,
    WAIT_OP = 3'd2,
    EXEC    = 3'd3,
    SHOW    = 3'd4
  } state_t;

  state_t state;
  logic   enter_q, undo_q;
  logic   enter_evt, undo_evt;

  assign enter_evt = Enter & ~enter_q;
  assign undo_evt  = Undo  & ~undo_q;
  assign Stage     = state;

  // Edge registers reset high so a button held through reset is not an event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= WAIT_A;
      enter_q    <= 1'b1;
      undo_q     <= 1'b1;
      alu.A      <= '0;
      alu.B      <= '0;
      alu.OpCode <= '0;
      ResultReg  <= '0;
      StatusReg  <= '0;
      Valid      <= 1'b0;
    end else begin
      enter_q <= Enter;
      undo_q  <= Undo;
      case (state)
        WAIT_A: begin
          if (!undo_evt && enter_evt) begin
            alu.A <= DataIn;
            state <= WAIT_B;
          end
        end
        WAIT_B: begin
          if (undo_evt) state <= WAIT_A;
          else if (enter_evt) begin
            alu.B <= DataIn;
            state <= WAIT_OP;
          end
        end
        WAIT_OP: begin
          if (undo_evt) state <= WAIT_B;
          else if (enter_evt) begin
            alu.OpCode <= DataIn[1:0];
            state      <= EXEC;
          end
        end
        EXEC: begin
          ResultReg <= alu.AluResult;
          StatusReg <= alu.AluStatus;
          Valid     <= 1'b1;
          state     <= SHOW;
        end
        SHOW: begin
          if (undo_evt) begin
            Valid <= 1'b0;
            state <= WAIT_OP;
          end else if (enter_evt) begin
            Valid <= 1'b0;
`ifdef ALU_SEQ_CHAIN_EN
            alu.A <= ResultReg;
            state <= WAIT_B;
`else
            state <= WAIT_A;
`endif
          end
        end
        default: state <= WAIT_A;
      endcase
    end
  end

endmodule

// File: doc/alu_operand_sequencer.md
# alu_operand_sequencer

Sequential front-end that drives the combinational ALU from a single data-entry port and an Enter/Undo button pair. It collects operand A, operand B and the opcode over successive Enter presses, presents them to the ALU, and registers the returned Result and Status for display. The block sits between the debounced board inputs (switches and buttons) and the ALU: it is the initiator, and the ALU is the responder.

## Interface

**Parameters**
- `C_WIDTH`, default 8: operand and result width. Must match the ALU instance.

**Ports**
- `clk`, input, 1: single system clock; all state updates on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `DataIn`, input, `C_WIDTH`: entry value. Only `[1:0]` is used when the opcode is entered.
- `Enter`, input, 1: level from a debounced button, synchronous to `clk`.
- `Undo`, input, 1: level from a debounced button, synchronous to `clk`.
- `A`, output, `C_WIDTH`: registered operand A to the ALU.
- `B`, output, `C_WIDTH`: registered operand B to the ALU.
- `OpCode`, output, 2: registered opcode to the ALU. Encoding: 0 = add, 1 = sub, 2 = or, 3 = and.
- `AluResult`, input, `C_WIDTH`: Result returned by the ALU.
- `AluStatus`, input, 4: Status `{N,Z,C,V}` returned by the ALU.
- `ResultReg`, output, `C_WIDTH`: captured result.
- `StatusReg`, output, 4: captured status.
- `Valid`, output, 1: high while `ResultReg`/`StatusReg` hold the result of the current operand set.
- `Stage`, output, 3: current state encoding, used for LEDs.

## Operation

**Edge detection**
- `enter_evt` = `Enter` & ~`enter_q`; `undo_evt` = `Undo` & ~`undo_q`.
- `enter_q` and `undo_q` reset to 1, so a button held through reset does not produce an event.

**States and `Stage` encoding**
- WAIT_A = 0, WAIT_B = 1, WAIT_OP = 2, EXEC = 3, SHOW = 4. Encodings 5–7 are unused and recover to WAIT_A on the next clock.

**Transitions on `enter_evt`** (applies only when `undo_evt` = 0)
- WAIT_A: `A` ← `DataIn`; go to WAIT_B.
- WAIT_B: `B` ← `DataIn`; go to WAIT_OP.
- WAIT_OP: `OpCode` ← `DataIn[1:0]`; go to EXEC.
- SHOW: behaviour depends on the configuration (see Configuration).

**EXEC**
- Lasts exactly one cycle, unconditionally.
- `ResultReg` ← `AluResult`, `StatusReg` ← `AluStatus`, `Valid` ← 1; go to SHOW.
- `enter_evt` and `undo_evt` arriving in EXEC are discarded.

**Transitions on `undo_evt`** (Undo wins when it coincides with Enter)
- WAIT_A: no effect.
- WAIT_B → WAIT_A.
- WAIT_OP → WAIT_B.
- SHOW → WAIT_OP, with `Valid` ← 0.
- Undo never clears `A`, `B` or `OpCode`; re-entry overwrites them.

**Valid**
- Cleared on any exit from SHOW. Set only by EXEC.

**Widths**
- All register loads are exact width. No sign extension or truncation other than `OpCode` = `DataIn[1:0]`.

## Timing

- Reset values: `A` = 0, `B` = 0, `OpCode` = 0, `ResultReg` = 0, `StatusReg` = 0, `Valid` = 0, `Stage` = 0 (WAIT_A).
- Reset asserted in any state returns the block to these values immediately, without waiting for a clock edge.
- Latency: if `Enter` is first sampled high at edge k in WAIT_OP, then `OpCode` updates and `Stage` = 3 after edge k. `ResultReg`, `StatusReg` and `Valid` = 1 update after edge k+1.
- The ALU combinational path from `A`/`B`/`OpCode` to `AluResult` must settle within one clock period.
- Enter held high for many cycles produces exactly one event. A new event requires `Enter` to be low for at least one sampled cycle.
- `A`, `B` and `OpCode` are stable outside their own load cycles, so the ALU inputs never glitch in SHOW.

## Configuration

- Macro: `ALU_SEQ_CHAIN_EN`.
- Defined: Enter in SHOW sets `A` ← `ResultReg`, `Valid` ← 0, and goes to WAIT_B. This chains the previous result into the next operation.
- Undefined: Enter in SHOW sets `Valid` ← 0 and goes to WAIT_A. `A`, `B` and `OpCode` keep their values until overwritten.

## Test plan

- **Reset with Enter held:** hold `Enter` = 1 through reset release → `Stage` stays 0 and no load occurs. Release, then press with `DataIn` = 0x12 → `A` = 0x12, `Stage` = 1.
- **Add with overflow:** enter A = 0x7F, B = 0x01, op = 0 → two edges after the op Enter: `ResultReg` = 0x80, `StatusReg` = 4'b1001, `Valid` = 1, `Stage` = 4.
- **Sub to zero:** enter A = 0x05, B = 0x05, op = 1 → `ResultReg` = 0x00, `StatusReg` = 4'b0100.
- **Undo chain:** enter A = 0x10 and B = 0x20, press Undo twice → `Stage` = 0 with `A` still 0x10. Simultaneous Enter+Undo in WAIT_B → `Stage` = 0 and `B` unchanged.
- **SHOW exit:** after 0x03 | 0x0C (op 2) with result 0x0F, press Enter. With `ALU_SEQ_CHAIN_EN` → `A` = 0x0F, `Stage` = 1, `Valid` = 0. Without it → `Stage` = 0, `Valid` = 0.
- **Reset mid-operation:** assert `rst_n` = 0 in EXEC or SHOW → all outputs return to reset values before the next clock edge.
